// File: rtl/dino_jump_ctrl_pkg.sv
// Shared types and geometry for the dino vertical motion engine.
package dino_jump_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2,
      ST_DUCK   = 2'd3
   } dino_state_e;

   localparam int unsigned STATE_W     = 2;
   localparam int unsigned SPRITE_H    = 60;
   localparam int unsigned GROUND_LINE = 335;

endpackage

// File: rtl/dino_jump_ctrl_btn_sync_edge.sv
// Two-flop button synchronizer with registered level and rising-edge pulse.
module dino_jump_ctrl_btn_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic lvl,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;

   always_comb begin
      meta_d = btn;
      sync_d = meta_q;
      prev_d = sync_q;
      rise_d = sync_q & ~prev_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   // level and pulse are both three clocks behind the pin
   assign lvl  = prev_q;
   assign rise = rise_q;

endmodule

// File: rtl/dino_jump_ctrl.sv
// Per-frame jump/fall/duck state machine driving the dino sprite top Y.
// Define DINO_VARIABLE_JUMP_EN to cut the rise short when up is released.
module dino_jump_ctrl
   import dino_jump_ctrl_pkg::*;
#(
   parameter int unsigned Y_W        = 10,
   parameter int unsigned GROUND_Y   = GROUND_LINE - SPRITE_H,
   parameter int unsigned JUMP_V     = 12,
   parameter int unsigned GRAVITY    = 1,
   parameter int unsigned MAX_FALL_V = 12
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               frame_tick,
   input  logic               up,
   input  logic               down,
   output logic [Y_W-1:0]     sprite_y,
   output logic               airborne,
   output logic               ducking,
   output logic [STATE_W-1:0] state
);

   localparam logic [Y_W-1:0] GROUND_Y_C = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0] JUMP_V_C   = Y_W'(JUMP_V);
   localparam logic [Y_W-1:0] GRAV_C     = Y_W'(GRAVITY);
   localparam logic [Y_W-1:0] GRAV2_C    = Y_W'(2 * GRAVITY);
   localparam logic [Y_W-1:0] MAX_FALL_C = Y_W'(MAX_FALL_V);

   logic up_lvl, up_rise, dn_lvl, dn_rise;
   logic sig_unused;

   dino_jump_ctrl_btn_sync_edge u_up_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (up),
      .lvl     (up_lvl),
      .rise    (up_rise)
   );

   dino_jump_ctrl_btn_sync_edge u_dn_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (down),
      .lvl     (dn_lvl),
      .rise    (dn_rise)
   );

`ifdef DINO_VARIABLE_JUMP_EN
   assign sig_unused = dn_rise;
`else
   assign sig_unused = dn_rise | up_lvl;
`endif

   dino_state_e    state_q, state_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [Y_W-1:0] vel_q, vel_d;
   logic           pend_q, pend_d;
   logic           airborne_q, airborne_d;
   logic           ducking_q, ducking_d;

   logic           grounded;
   logic [Y_W-1:0] fall_g;
   logic [Y_W:0]   vel_sum;
   logic [Y_W-1:0] fall_v;
   logic [Y_W:0]   fall_y;

   // next state, physics and pending-jump bookkeeping
   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      vel_d    = vel_q;
      grounded = (state_q == ST_GROUND) || (state_q == ST_DUCK);
      pend_d   = pend_q | (up_rise & grounded);

      fall_g  = dn_lvl ? GRAV2_C : GRAV_C;
      vel_sum = {1'b0, vel_q} + {1'b0, fall_g};
      fall_v  = (vel_sum > {1'b0, MAX_FALL_C}) ? MAX_FALL_C : vel_sum[Y_W-1:0];
      fall_y  = {1'b0, y_q} + {1'b0, fall_v};

      if (frame_tick) begin
         unique case (state_q)
            ST_GROUND, ST_DUCK: begin
               y_d = GROUND_Y_C;
               if (pend_q) begin
                  state_d = ST_RISE;
                  vel_d   = JUMP_V_C;
                  pend_d  = 1'b0;
               end else if (dn_lvl) begin
                  state_d = ST_DUCK;
               end else begin
                  state_d = ST_GROUND;
               end
            end
            ST_RISE: begin
               y_d = (vel_q > y_q) ? '0 : y_q - vel_q;
               if (vel_q <= GRAV_C) begin
                  state_d = ST_FALL;
                  vel_d   = '0;
`ifdef DINO_VARIABLE_JUMP_EN
               end else if (!up_lvl && (vel_q > Y_W'(2))) begin
                  vel_d = vel_q >> 1;
`endif
               end else begin
                  vel_d = vel_q - GRAV_C;
               end
            end
            ST_FALL: begin
               if (fall_y >= {1'b0, GROUND_Y_C}) begin
                  state_d = ST_GROUND;
                  y_d     = GROUND_Y_C;
                  vel_d   = '0;
               end else begin
                  y_d   = fall_y[Y_W-1:0];
                  vel_d = fall_v;
               end
            end
            default: state_d = ST_GROUND;
         endcase
      end

      airborne_d = (state_d == ST_RISE) || (state_d == ST_FALL);
      ducking_d  = (state_d == ST_DUCK);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_GROUND;
         y_q        <= GROUND_Y_C;
         vel_q      <= '0;
         pend_q     <= 1'b0;
         airborne_q <= 1'b0;
         ducking_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         vel_q      <= vel_d;
         pend_q     <= pend_d;
         airborne_q <= airborne_d;
         ducking_q  <= ducking_d;
      end
   end

   assign sprite_y = y_q;
   assign airborne = airborne_q;
   assign ducking  = ducking_q;
   assign state    = state_q;

endmodule
